// File: rtl/multi_channel_timer.sv
// CHANNELS independent down-counting tick timers sharing one system clock.
// Each channel runs its own prescaler phase and supports one-shot or auto-reload operation.
module multi_channel_timer #(
  parameter int unsigned CLOCK_HZ    = 125_000_000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned COUNT_WIDTH = 4
) (
  input  logic                            clock,
  input  logic                            resetN,
  input  logic [CHANNELS-1:0]             start,
  input  logic [CHANNELS-1:0]             stop,
  input  logic [CHANNELS-1:0]             periodic,
  input  logic [CHANNELS*COUNT_WIDTH-1:0] value,
  output logic [CHANNELS-1:0]             running,
  output logic [CHANNELS-1:0]             expired,
  output logic [CHANNELS-1:0]             tick,
  output logic [CHANNELS*COUNT_WIDTH-1:0] remaining
);

  localparam int unsigned DIVIDE  = CLOCK_HZ / TICK_HZ;
  localparam int unsigned PHASE_W = (DIVIDE > 2) ? $clog2(DIVIDE) : 1;
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DIVIDE - 1);

  if (DIVIDE < 2) begin : g_divide_check
    $error("multi_channel_timer: CLOCK_HZ / TICK_HZ must be at least 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t                 state_q, state_d;
    logic [PHASE_W-1:0]     phase_q, phase_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic [COUNT_WIDTH-1:0] reload_q, reload_d;
    logic [COUNT_WIDTH-1:0] load_val;
    logic                   mode_q, mode_d;
    logic                   tick_q, tick_d;
    logic                   exp_q, exp_d;
    logic                   zero_load, wrap, last;

    assign load_val  = value[i*COUNT_WIDTH +: COUNT_WIDTH];
    assign zero_load = (load_val == '0);
    assign wrap      = (state_q == RUN) && (phase_q == LAST_PHASE);
    // rem_q can never be 0 in RUN, so <= 1 only guards against underflow
    assign last      = wrap && (rem_q <= COUNT_WIDTH'(1));

    // State and datapath registers
    always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
        state_q  <= IDLE;
        phase_q  <= '0;
        rem_q    <= '0;
        reload_q <= '0;
        mode_q   <= 1'b0;
        tick_q   <= 1'b0;
        exp_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        phase_q  <= phase_d;
        rem_q    <= rem_d;
        reload_q <= reload_d;
        mode_q   <= mode_d;
        tick_q   <= tick_d;
        exp_q    <= exp_d;
      end
    end

    // Next state: start beats stop beats terminal count
    always_comb begin
      state_d = state_q;
      if (start[i]) begin
        state_d = zero_load ? IDLE : RUN;
      end else if (stop[i]) begin
        state_d = IDLE;
      end else if (last && !mode_q) begin
        state_d = IDLE;
      end
    end

    // Datapath next values and pulse outputs
    always_comb begin
      phase_d  = phase_q;
      rem_d    = rem_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      tick_d   = 1'b0;
      exp_d    = 1'b0;
      if (start[i]) begin
        phase_d  = '0;
        rem_d    = load_val;
        reload_d = load_val;
        mode_d   = periodic[i];
        exp_d    = zero_load;
      end else if (stop[i]) begin
        phase_d = '0;
        rem_d   = '0;
      end else if (wrap) begin
        phase_d = '0;
        tick_d  = 1'b1;
        if (last) begin
          exp_d = 1'b1;
          rem_d = mode_q ? reload_q : '0;
        end else begin
          rem_d = rem_q - COUNT_WIDTH'(1);
        end
      end else if (state_q == RUN) begin
        phase_d = phase_q + PHASE_W'(1);
      end
    end

    assign running[i]                            = (state_q == RUN);
    assign tick[i]                               = tick_q;
    assign expired[i]                            = exp_q;
    assign remaining[i*COUNT_WIDTH +: COUNT_WIDTH] = rem_q;
  end

endmodule

// File: doc/multi_channel_timer.md
# multi_channel_timer

Parametrised successor to the single-channel 1 Hz timer. It provides CHANNELS independent down-counting timers, each with its own prescaler phase, selectable one-shot or periodic mode, stop/cancel, and a readable remaining count. It sits between the alarm/arming FSMs and the indicator logic. Typical uses are the entry delay, exit delay, siren timeout and LED blink period, each timed concurrently from the single system clock.

## Interface
- CLOCK_HZ, 125_000_000, system clock frequency.
- TICK_HZ, 1, timer resolution; DIVIDE = CLOCK_HZ / TICK_HZ (integer), DIVIDE >= 2 required (elaboration error otherwise).
- CHANNELS, 4, number of independent timers, >= 1.
- COUNT_WIDTH, 4, width of each channel's tick count.

- clock  in  1  system clock, all state on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- start  in  CHANNELS  per-channel start/restart strobe, level sampled each edge.
- stop  in  CHANNELS  per-channel cancel strobe.
- periodic  in  CHANNELS  mode for channel i, captured on start: 1 = auto-reload, 0 = one-shot.
- value  in  CHANNELS*COUNT_WIDTH  tick count for channel i at bits [i*COUNT_WIDTH +: COUNT_WIDTH], captured on start.
- running  out  CHANNELS  channel i active.
- expired  out  CHANNELS  one-cycle pulse at the terminal count of channel i.
- tick  out  CHANNELS  one-cycle pulse at each elapsed tick of channel i while running.
- remaining  out  CHANNELS*COUNT_WIDTH  whole ticks left on channel i.

## Operation
- Per-channel state: mode bit, reload register (COUNT_WIDTH), remaining (COUNT_WIDTH), phase counter (clog2(DIVIDE) bits), FSM IDLE/RUN.
- IDLE: phase = 0, remaining = 0, running = 0, no tick or expired pulses.
- start[i] in any state loads reload = remaining = value[i], captures periodic[i], sets phase = 0 and enters RUN. This also restarts a running channel.
- value 0 on start: the channel does not enter RUN. It pulses expired on the next cycle and stays IDLE, in either mode.
- RUN: phase increments each cycle. At phase == DIVIDE-1, phase wraps to 0, tick pulses and remaining decrements.
- When remaining decrements from 1 to 0, expired pulses in the same cycle as tick.
  - One-shot: go to IDLE.
  - Periodic: remaining = reload, phase = 0, stay in RUN with no gap cycle.
- stop[i]: go to IDLE with no expired or tick pulse. stop in IDLE has no effect.
- Priority per channel: start > stop > terminal count. A start coinciding with the terminal cycle suppresses that expired pulse and restarts.
- Channels are fully independent. Simultaneous events on different channels do not interact.
- Arithmetic: remaining never underflows; decrement occurs only when remaining >= 1. Phase compare is exact against DIVIDE-1.
- Inputs are synchronous to clock. Upstream handles metastability.

## Timing
- Reset (asynchronous assert, synchronous-release domain): all channels IDLE; running, expired, tick = 0; remaining = 0; phase = 0.
- Outputs are registered, with no combinational path from inputs to outputs.
- start sampled at edge E with value N >= 1:
  - running = 1 and remaining = N after E.
  - tick pulses in the cycle after edge E + k*DIVIDE for k = 1..N.
  - expired pulses together with the k = N tick.
  - One-shot: running = 0 after edge E + N*DIVIDE.
- Total one-shot latency is exactly N*DIVIDE cycles from the start edge to the expired-high cycle.
- Periodic period is exactly N*DIVIDE cycles between expired pulses.
- stop sampled at edge E: running = 0 and remaining = 0 after E.
- Reset asserted mid-count: immediate return to reset values, with no expired pulse on release.

## Test plan
Use CLOCK_HZ=10, TICK_HZ=1 (DIVIDE=10), CHANNELS=4, COUNT_WIDTH=4.
- Reset check: hold resetN=0, then release. All outputs are 0 and stay 0 for 100 cycles with no strobes.
- One-shot: start[0] with value=3, periodic=0. Expect tick at +10, +20 and +30 cycles, expired[0] exactly at +30, remaining sequence 3,2,1,0, and running low after +30.
- Periodic: start[1] with value=2, periodic=1. Expect expired[1] at +20, +40 and +60, remaining reloading to 2, and running held high. Then stop at +45: no further pulses and remaining=0.
- Restart and priority: start[2] with value=5, then re-start with value=2 at +25. Expect expired at +45 only. Separately, assert start on the terminal cycle: no expired pulse that cycle, and a fresh count begins.
- Edge values: value=0 gives expired one cycle after start with running never high. value=15 gives expired at +150. Assert start and stop on the same cycle: start wins.
- Concurrency and reset: run all 4 channels with values 1, 2, 3, 4 started on different cycles and check independent expiry times. Drop resetN at +17: all outputs are 0 immediately and there is no expiry after release.
